// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared ALU: accepts one operation,
// screens illegal opcodes, issues a single-cycle enable and returns the captured result.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic        req1_cin,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_sign,
  output logic        rsp_err,
  output logic        busy,
  output logic        alu_enable,
  output logic [7:0]  alu_operation,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic        alu_cpu_carry,
  input  logic [7:0]  alu_result_l,
  input  logic [7:0]  alu_result_h,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [7:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        cin_q, cin_d;
  logic [15:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;

  logic        grant0, grant1;
  logic [7:0]  win_op;

  function automatic logic is_legal(input logic [7:0] op);
    return (op == 8'h01) || (op == 8'h02) || (op == 8'h03) ||
           ((op >= 8'h06) && (op <= 8'h0A)) ||
           ((op >= 8'h8E) && (op <= 8'h9B));
  endfunction

  // Grants are only meaningful in IDLE; prio_q breaks the tie when both are valid.
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);
  assign win_op = grant1 ? req1_op : req0_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          op_d    = win_op;
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          cin_d   = grant1 ? req1_cin : req0_cin;
          if (is_legal(win_op)) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            res_d   = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
            sign_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        res_d   = {alu_result_h, alu_result_l};
        carry_d = alu_carry;
        zero_d  = alu_zero;
        sign_d  = alu_sign;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && grant0 && !rst;
    req1_ready = (state_q == IDLE) && grant1 && !rst;
    rsp0_valid = (state_q == RESP) && !owner_q;
    rsp1_valid = (state_q == RESP) &&  owner_q;
    busy       = (state_q != IDLE);
    alu_enable = (state_q == ISSUE);
  end

  assign alu_operation = op_q;
  assign alu_op1       = a_q;
  assign alu_op2       = b_q;
  assign alu_cpu_carry = cin_q;
  assign rsp_result    = res_q;
  assign rsp_carry     = carry_q;
  assign rsp_zero      = zero_q;
  assign rsp_sign      = sign_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU stand-in.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_op = '0, req0_a = '0, req0_b = '0;
  logic [7:0]  req1_op = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [15:0] rsp_result;
  logic        rsp_carry, rsp_zero, rsp_sign, rsp_err, busy;
  logic        alu_enable, alu_cpu_carry;
  logic [7:0]  alu_operation, alu_op1, alu_op2;
  logic [7:0]  alu_result_l = '0, alu_result_h = '0;
  logic        alu_carry = 1'b0, alu_zero = 1'b0, alu_sign = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .rsp_sign(rsp_sign), .rsp_err(rsp_err), .busy(busy),
    .alu_enable(alu_enable), .alu_operation(alu_operation),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cpu_carry(alu_cpu_carry),
    .alu_result_l(alu_result_l), .alu_result_h(alu_result_h),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  // ALU stand-in: add 0x8E, mul 0x92, RLC 0x08; results registered on enable.
  logic [15:0] m_r;
  logic        m_c;
  always @(posedge clk) begin
    if (alu_enable) begin
      m_r = '0;
      m_c = 1'b0;
      case (alu_operation)
        8'h8E: {m_c, m_r[7:0]} = {1'b0, alu_op1} + {1'b0, alu_op2};
        8'h92: m_r = alu_op1 * alu_op2;
        8'h08: begin m_r = {8'h00, alu_op1[6:0], alu_cpu_carry}; m_c = alu_op1[7]; end
        default: m_r = '0;
      endcase
      alu_result_l <= m_r[7:0];
      alu_result_h <= m_r[15:8];
      alu_carry    <= m_c;
      alu_zero     <= (m_r == 16'h0000);
      alu_sign     <= m_r[7];
    end
  end

  task automatic check_reset_values(input string tag);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, busy} !== 6'b0) begin
      errors++;
      $display("FAIL %s_ctrl: got %b exp 000000", tag,
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, alu_enable, busy});
    end
    checks++;
    if ({alu_operation, alu_op1, alu_op2, alu_cpu_carry} !== 25'h0) begin
      errors++;
      $display("FAIL %s_alu_out: got %h exp 0", tag, {alu_operation, alu_op1, alu_op2, alu_cpu_carry});
    end
    checks++;
    if (rsp_result !== 16'h0000) begin
      errors++;
      $display("FAIL %s_result: got %h exp 0000", tag, rsp_result);
    end
    checks++;
    if ({rsp_carry, rsp_zero, rsp_sign, rsp_err} !== 4'b0) begin
      errors++;
      $display("FAIL %s_flags: got %b exp 0000", tag, {rsp_carry, rsp_zero, rsp_sign, rsp_err});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    #1;
    check_reset_values("reset");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention;
    int grants[$];
    int gcyc[$];
    int enables = 0;
    int n_rsp0 = 0, n_rsp1 = 0;
    logic [15:0] exp_res;
    req0_op = 8'h92; req0_a = 8'h10; req0_b = 8'h10;
    req1_op = 8'h92; req1_a = 8'h03; req1_b = 8'h05;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL cont_dual_ready: cycle %0d both readies high", c);
      end
      if (req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
      if (req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
      if (alu_enable) enables++;
      if (rsp0_valid || rsp1_valid) begin
        exp_res = rsp0_valid ? 16'h0100 : 16'h000F;
        if (rsp0_valid) n_rsp0++; else n_rsp1++;
        checks++;
        if (rsp_result !== exp_res || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL cont_result: cycle %0d got %h err %b exp %h err 0", c, rsp_result, rsp_err, exp_res);
        end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checks++;
    if (grants.size() != 4) begin
      errors++;
      $display("FAIL cont_grant_count: got %0d exp 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != (i % 2) || gcyc[i] != 4 * i) begin
          errors++;
          $display("FAIL cont_grant%0d: got port %0d at cycle %0d exp port %0d at cycle %0d",
                   i, grants[i], gcyc[i], i % 2, 4 * i);
        end
      end
    end
    checks++;
    if (enables != 4) begin
      errors++;
      $display("FAIL cont_enables: got %0d exp 4", enables);
    end
    checks++;
    if (n_rsp0 != 2 || n_rsp1 != 2) begin
      errors++;
      $display("FAIL cont_rsp_count: got %0d/%0d exp 2/2", n_rsp0, n_rsp1);
    end
    @(negedge clk);
  endtask

  task automatic test_single_add;
    req0_op = 8'h8E; req0_a = 8'h80; req0_b = 8'h90; req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      errors++;
      $display("FAIL add_accept: got rdy0/rdy1/busy %b exp 100", {req0_ready, req1_ready, busy});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({alu_enable, busy} !== 2'b11 || {alu_operation, alu_op1, alu_op2} !== 24'h8E8090) begin
      errors++;
      $display("FAIL add_issue: got en/busy %b alu %h exp 11 8e8090", {alu_enable, busy},
               {alu_operation, alu_op1, alu_op2});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({alu_enable, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL add_wait: got en/rsp0 %b exp 00", {alu_enable, rsp0_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_result !== 16'h0010 || rsp_carry !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp: got v %b res %h c %b e %b exp 10 0010 1 0", {rsp0_valid, rsp1_valid},
               rsp_result, rsp_carry, rsp_err);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("FAIL add_idle: got busy/rsp0 %b exp 00", {busy, rsp0_valid});
    end
  endtask

  task automatic test_illegal;
    req1_op = 8'h05; req1_a = 8'h12; req1_b = 8'h34; req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL ill_accept: got %b exp 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp_err, alu_enable} !== 4'b1010 || rsp_result !== 16'h0000 ||
        {rsp_carry, rsp_zero, rsp_sign} !== 3'b000) begin
      errors++;
      $display("FAIL ill_rsp: got v1/v0/err/en %b res %h flags %b exp 1010 0000 000",
               {rsp1_valid, rsp0_valid, rsp_err, alu_enable}, rsp_result, {rsp_carry, rsp_zero, rsp_sign});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, alu_enable, rsp1_valid} !== 3'b000) begin
      errors++;
      $display("FAIL ill_idle: got busy/en/rsp1 %b exp 000", {busy, alu_enable, rsp1_valid});
    end
    req1_op = 8'h8E; req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if (alu_enable !== 1'b1) begin
      errors++;
      $display("FAIL ill_next_issue: got %b exp 1", alu_enable);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp_result !== 16'h0003 || {rsp_carry, rsp_err} !== 2'b00) begin
      errors++;
      $display("FAIL ill_next_rsp: got v %b res %h c/e %b exp 1 0003 00", rsp1_valid, rsp_result,
               {rsp_carry, rsp_err});
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    rsp0_ready = 1'b0;
    req0_op = 8'h8E; req0_a = 8'h7F; req0_b = 8'h01; req0_valid = 1'b1;
    req1_op = 8'h8E; req1_a = 8'h11; req1_b = 8'h22; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bp_accept: got %b exp 10", {req0_ready, req1_ready});
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b1000 || rsp_result !== 16'h0080 ||
          {rsp_carry, rsp_zero, rsp_sign, rsp_err} !== 4'b0010) begin
        errors++;
        $display("FAIL bp_hold%0d: got v/rdy %b res %h flags %b exp 1000 0080 0010", i,
                 {rsp0_valid, rsp1_valid, req0_ready, req1_ready}, rsp_result,
                 {rsp_carry, rsp_zero, rsp_sign, rsp_err});
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, rsp0_valid, req0_ready, req1_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release: got busy/v0/rdy0/rdy1 %b exp 0001", {busy, rsp0_valid, req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_carry_in;
    req0_op = 8'h08; req0_a = 8'h81; req0_b = 8'h00; req0_cin = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req0_cin = 1'b0;
    #1;
    checks++;
    if ({alu_enable, alu_cpu_carry} !== 2'b11 || alu_operation !== 8'h08 || alu_op1 !== 8'h81) begin
      errors++;
      $display("FAIL rlc_issue: got en/cin %b op %h a %h exp 11 08 81", {alu_enable, alu_cpu_carry},
               alu_operation, alu_op1);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_result !== 16'h0003 || rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL rlc_rsp: got v %b res %h c %b exp 1 0003 1", rsp0_valid, rsp_result, rsp_carry);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_wait;
    req1_op = 8'h8E; req1_a = 8'h05; req1_b = 8'h06; req1_valid = 1'b1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstw_accept: got %b exp 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_values("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rstw_no_rsp: got %b exp 000", {busy, rsp0_valid, rsp1_valid});
    end
    req0_op = 8'h8E; req1_op = 8'h8E;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rstw_prio: got %b exp 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, alu_enable} !== 4'b0000) begin
      errors++;
      $display("FAIL rstw_quiet: got %b exp 0000", {busy, rsp0_valid, rsp1_valid, alu_enable});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_issue;
    req1_op = 8'h92; req1_a = 8'h02; req1_b = 8'h02; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if (alu_enable !== 1'b1) begin
      errors++;
      $display("FAIL rsti_issue: got %b exp 1", alu_enable);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({alu_enable, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rsti_drop: got en/busy %b exp 00", {alu_enable, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_add();
    test_illegal();
    test_backpressure();
    test_carry_in();
    test_reset_wait();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `alu` datapath between two requesters, e.g. the CPU execute stage (port 0) and a background checksum/DMA engine (port 1). Accepts one operation at a time over a valid/ready handshake and arbitrates round-robin. It drives the ALU's enable, opcode and operand inputs for exactly one cycle, captures the registered ALU result and flags, and returns them to the winning requester. It also screens out unsupported opcodes before they reach the ALU.

## Interface
Parameters:
- `RR_INIT`, default 0: port holding priority after reset (0 or 1).

Ports, per line as name, direction, width, meaning:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `reqN_valid` input 1 (N=0,1): request pending; fields are held stable until accepted.
- `reqN_ready` output 1: accept strobe. A transfer occurs when valid&ready on a rising edge.
- `reqN_op` input 8: ALU opcode.
- `reqN_a`, `reqN_b` input 8 each: operands op1, op2.
- `reqN_cin` input 1: carry-in for RLC/RRC.
- `rspN_valid` output 1: response for port N.
- `rspN_ready` input 1: response consumed when valid&ready.
- `rsp_result` output 16: {result_h, result_l}; shared by both ports, qualified by `rspN_valid`.
- `rsp_carry`, `rsp_zero`, `rsp_sign`, `rsp_err` output 1 each: captured flags; `rsp_err` marks an illegal opcode.
- `busy` output 1: high whenever state is not IDLE.
- `alu_enable` output 1, `alu_operation` output 8, `alu_op1` output 8, `alu_op2` output 8, `alu_cpu_carry` output 1: drive the ALU.
- `alu_result_l`, `alu_result_h` input 8 each; `alu_carry`, `alu_zero`, `alu_sign` input 1 each: ALU registered outputs.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request is valid, stay in IDLE.
  - If only one port is valid, that port wins.
  - If both are valid, the port holding priority wins.
  - The winner gets `reqN_ready`=1 combinationally in this cycle. op, a, b, cin and the owner index are latched.
  - Next state is ISSUE if the opcode is legal, otherwise RESP with the error response.
- Legal opcodes: 0x01, 0x02, 0x03, 0x06–0x0A, 0x8E–0x9B. All others are illegal.
- ISSUE: `alu_enable`=1 and the latched fields are driven for exactly one cycle. Next state is WAIT.
- WAIT: the ALU outputs are valid this cycle and are registered into the `rsp_*` registers with `rsp_err`=0. Next state is RESP.
- Illegal opcode response: `rsp_result`=0, `rsp_carry`=`rsp_zero`=`rsp_sign`=0, `rsp_err`=1. The ALU is never enabled.
- RESP:
  - `rsp<owner>_valid`=1 and is held, with data stable, until `rsp<owner>_ready`.
  - On the handshake, priority passes to the other port (the owner becomes lowest priority) and the next state is IDLE.
- ALU side when not in ISSUE: `alu_enable`=0. The `alu_*` data outputs hold their last latched values.
- Flags are passed through exactly as the ALU reports them. The arbiter adds no flag logic.
- `reqN_ready` is never asserted outside IDLE. Only one ready is asserted per cycle.

## Timing
- Reset values:
  - state=IDLE, priority=`RR_INIT`.
  - All `reqN_ready`, `rspN_valid`, `alu_enable` and `busy` = 0.
  - `alu_operation`, `alu_op1`, `alu_op2`, `alu_cpu_carry` = 0.
  - `rsp_result`=0, all `rsp_*` flags=0.
- Legal op, cycle by cycle:
  - Accept edge at T.
  - `alu_enable` is high during T+1.
  - Capture on the edge ending T+2.
  - `rspN_valid` is high from T+3.
- Illegal op: `rspN_valid` is high from T+1.
- Back-to-back throughput: with rsp_ready tied high, one operation per 4 cycles.
- A request arriving in any state other than IDLE waits; it is not lost.
- Deasserting `reqN_valid` before ready is outside the protocol; the behaviour is undefined.
- Asserting `rst` mid-operation, in any state:
  - The FSM returns to IDLE and the in-flight operation is dropped with no response.
  - Priority returns to `RR_INIT`.
  - `alu_enable` drops immediately (asynchronous reset).

## Test plan
- Single add on port 0: op=0x8E, a=0x80, b=0x90. Expect ready on the accept cycle, one `alu_enable` pulse at T+1, `rsp0_valid` at T+3, `rsp_result`=0x0010, `rsp_carry`=1, `rsp_err`=0.
- Contention: both ports valid continuously with `RR_INIT`=0. Expect grants 0,1,0,1 and exactly one `alu_enable` pulse per grant. Mul 0x92, a=0x10, b=0x10 returns `rsp_result`=0x0100.
- Illegal opcode 0x05 on port 1:
  - `alu_enable` never rises.
  - `rsp1_valid` is high at T+1 with `rsp_err`=1 and `rsp_result`=0.
  - The next legal request then completes normally.
- Backpressure: `rsp0_ready` held low for 10 cycles. Expect `rsp0_valid` and the data stable throughout, no new ready to either port, and IDLE on the cycle after ready rises.
- Carry-in path: RLC op=0x08, a=0x81, cin=1. Expect `alu_cpu_carry`=1 during ISSUE, `rsp_result`=0x0003, `rsp_carry`=1.
- Reset in WAIT: assert `rst`. Expect all outputs at their reset values, no `rspN_valid`, and priority back to `RR_INIT` on the next contention.
